// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// Results are returned through a one-deep registered, tagged response buffer.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow
);
  logic [WIDTH-1:0] sum, diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (aluctl)
      4'd0:  out = a & b;
      4'd1:  out = a | b;
      4'd2: begin
        out      = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd6: begin
        out      = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7:  out = {{(WIDTH-1){1'b0}}, a == b};
      4'd12: out = ~(a | b);
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);
  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;
    logic             err;
  } rsp_t;

  rsp_t             rsp_q, rsp_d;
  logic             vld_q;
  logic             last_grant;
  logic             can_accept;
  logic             gnt0, gnt1;
  logic             issue;
  logic [3:0]       sel_ctl;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero, alu_ovf;
  logic             supported;

  // Tie goes to whoever did not win last; reset gates ready so nothing issues in a reset cycle.
  assign can_accept = (!vld_q || rsp_ready) && !reset;
  assign gnt0       = req0_valid && (!req1_valid || last_grant);
  assign gnt1       = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = can_accept && gnt0;
  assign req1_ready = can_accept && gnt1;
  assign issue      = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_ctl = gnt1 ? req1_ctl : req0_ctl;
  assign sel_a   = gnt1 ? req1_a   : req0_a;
  assign sel_b   = gnt1 ? req1_b   : req0_b;

  alu #(.WIDTH(WIDTH)) u_alu (
    .aluctl   (sel_ctl),
    .a        (sel_a),
    .b        (sel_b),
    .out      (alu_out),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  always_comb begin
    case (sel_ctl)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: supported = 1'b1;
      default:                             supported = 1'b0;
    endcase
  end

  // Unsupported codes discard the ALU result entirely and flag an error.
  always_comb begin
    rsp_d.id       = gnt1;
    rsp_d.out      = supported ? alu_out  : '0;
    rsp_d.zero     = supported ? alu_zero : 1'b0;
    rsp_d.overflow = supported ? alu_ovf  : 1'b0;
    rsp_d.err      = !supported;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q      <= '0;
      vld_q      <= 1'b0;
      last_grant <= 1'b1;
      op_count   <= '0;
    end else if (issue) begin
      rsp_q      <= rsp_d;
      vld_q      <= 1'b1;
      last_grant <= gnt1;
      op_count   <= op_count + 1'b1;
    end else if (vld_q && rsp_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign rsp_valid    = vld_q;
  assign rsp_id       = rsp_q.id;
  assign rsp_out      = rsp_q.out;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_err      = rsp_q.err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter; counter narrowed to 4 bits to exercise wrap.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_ctl, req1_ctl;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_err;
  logic [WIDTH-1:0] rsp_out;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 1'b0;
    req0_ctl = 0; req1_ctl = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    step(); step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err});
    checks++;
    if (rsp_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", rsp_out); end
    checks++;
    if (op_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", op_count); end
    reset = 1'b0;
    #1;
    // First-tie priority goes to requester 0.
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_tie got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_add();
    rsp_ready = 1; req0_valid = 1; req0_ctl = 4'd2; req0_a = 5; req0_b = 7;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err} !== 5'b10000) begin
      errors++; $display("FAIL add_flags got %b want 10000", {rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err});
    end
    checks++;
    if (rsp_out !== 32'd12) begin errors++; $display("FAIL add_out got %h want 0000000c", rsp_out); end
    checks++;
    if (op_count !== 4'd1) begin errors++; $display("FAIL add_count got %0d want 1", op_count); end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_alternate();
    reset = 1; step(); reset = 0;
    rsp_ready = 1;
    req0_valid = 1; req0_ctl = 4'd0; req0_a = 32'h0F0F0F0F; req0_b = 32'hF0F0F0F0;
    req1_valid = 1; req1_ctl = 4'd1; req1_a = 32'h00027024; req1_b = 32'h22DA3709;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== i[0]) begin
        errors++; $display("FAIL alt_id[%0d] got v=%b id=%b want v=1 id=%b", i, rsp_valid, rsp_id, i[0]);
      end
      checks++;
      if (i[0] == 1'b0) begin
        if (rsp_out !== 32'h0 || rsp_zero !== 1'b1) begin
          errors++; $display("FAIL alt_and[%0d] got %h z=%b want 00000000 z=1", i, rsp_out, rsp_zero);
        end
      end else begin
        if (rsp_out !== 32'h22DA772D || rsp_zero !== 1'b0) begin
          errors++; $display("FAIL alt_or[%0d] got %h z=%b want 22da772d z=0", i, rsp_out, rsp_zero);
        end
      end
    end
    checks++;
    if (op_count !== 4'd4) begin errors++; $display("FAIL alt_count got %0d want 4", op_count); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_stall();
    req1_valid = 1; req1_ctl = 4'd6; req1_a = 3; req1_b = 3;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_ctl = 4'd2; req0_a = 1; req0_b = 1;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, req0_ready); end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_zero !== 1'b1 || rsp_out !== 32'h0 || op_count !== 4'd5) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b id=%b z=%b out=%h cnt=%0d want v=1 id=1 z=1 out=0 cnt=5",
                           i, rsp_valid, rsp_id, rsp_zero, rsp_out, op_count);
      end
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'd2 || op_count !== 4'd6) begin
      errors++; $display("FAIL stall_release got v=%b id=%b out=%h cnt=%0d want v=1 id=0 out=2 cnt=6",
                         rsp_valid, rsp_id, rsp_out, op_count);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  ctl_t [6] = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd15};
    logic [31:0] a_t   [6] = '{32'h7FFFFFFF, 32'h1, 32'h80000000, 32'd5, 32'h0, 32'h5};
    logic [31:0] b_t   [6] = '{32'h1, 32'h2, 32'h1, 32'd5, 32'h0, 32'h5};
    logic [31:0] out_t [6] = '{32'h80000000, 32'h0, 32'h7FFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0};
    logic [2:0]  zoe_t [6] = '{3'b010, 3'b001, 3'b010, 3'b000, 3'b000, 3'b001};
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_ctl = ctl_t[i]; req0_a = a_t[i]; req0_b = b_t[i];
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== out_t[i] || {rsp_zero, rsp_overflow, rsp_err} !== zoe_t[i]) begin
        errors++; $display("FAIL op[%0d] ctl=%0d got v=%b out=%h zoe=%b want v=1 out=%h zoe=%b",
                           i, ctl_t[i], rsp_valid, rsp_out, {rsp_zero, rsp_overflow, rsp_err}, out_t[i], zoe_t[i]);
      end
    end
    req0_valid = 0;
    checks++;
    if (op_count !== 4'd12) begin errors++; $display("FAIL ops_count got %0d want 12", op_count); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0;
    req0_valid = 1; req0_ctl = 4'd2; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_ctl = 4'd2; req1_a = 3; req1_b = 4;
    reset = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready got %b want 00", {req0_ready, req1_ready}); end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 4'd0) begin
      errors++; $display("FAIL rstmid_state got v=%b cnt=%0d want v=0 cnt=0", rsp_valid, op_count);
    end
    reset = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_grant got %b want 10", {req0_ready, req1_ready}); end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'd3) begin
      errors++; $display("FAIL rstmid_rsp got v=%b id=%b out=%h want v=1 id=0 out=3", rsp_valid, rsp_id, rsp_out);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_back_to_back();
    int hs;
    hs = 0;
    reset = 1; rsp_ready = 1; step(); reset = 0;
    req0_valid = 1; req0_ctl = 4'd2; req0_b = 0;
    req1_valid = 1; req1_ctl = 4'd2; req1_b = 100;
    for (int i = 0; i < 16; i++) begin
      req0_a = i; req1_a = i;
      step();
      if (rsp_valid && rsp_ready) hs++;
      checks++;
      if (rsp_id !== i[0] || rsp_out !== (i[0] ? i + 100 : i)) begin
        errors++; $display("FAIL b2b_rsp[%0d] got id=%b out=%0d want id=%b out=%0d", i, rsp_id, rsp_out, i[0], i[0] ? i + 100 : i);
      end
      if (i == 14) begin
        checks++;
        if (op_count !== 4'd15) begin errors++; $display("FAIL b2b_count15 got %0d want 15", op_count); end
      end
    end
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (op_count !== 4'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", op_count); end
    step();
    checks++;
    if (hs != 16 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_handshakes got %0d v=%b want 16 v=0", hs, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alternate();
    test_stall();
    test_ops();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle ALU between two requesters, for example the integer pipeline and a CNN accumulation engine.
- Arbitration is round-robin with valid/ready handshakes.
- The block instantiates one alu (aluctl, a, b -> out, zero, overflow) internally.
- Each result is registered and returned on one tagged response channel with 1-cycle latency.

Parameters:
- WIDTH, 32, operand/result width; must match the alu datapath width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctl  in  4  requester 0 aluctl code.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_id  out  1  index of the requester that issued the result.
- rsp_out  out  WIDTH  registered alu out.
- rsp_zero  out  1  registered alu zero.
- rsp_overflow  out  1  registered alu overflow.
- rsp_err  out  1  the issued ctl was not a supported code.
- op_count  out  CNT_W  number of accepted operations, wraps.

Behaviour:
- Reset (synchronous, active-high; clk and reset as above): rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, rsp_overflow=0, rsp_err=0, op_count=0, last_grant=1 (so requester 0 wins the first tie).
- can_accept = !rsp_valid | rsp_ready. Response register is a 1-deep buffer: issue allowed when empty or draining this cycle.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant goes to !last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & granted(N). Ready may depend on valid. At most one ready per cycle.
- Issue occurs when reqN_valid & reqN_ready. On the same edge:
  - rsp_* load the ALU result for the granted operands.
  - rsp_id=N, rsp_valid=1.
  - last_grant=N.
  - op_count increments.
- Latency: operation accepted at edge k; result visible after edge k, held until rsp_ready.
- Drain only (rsp_valid & rsp_ready, no issue): rsp_valid -> 0. Data fields hold their last value.
- Simultaneous drain and issue: the new result replaces the old one with no bubble, giving a throughput of 1 op/cycle.
- rsp_ready=0 with rsp_valid=1:
  - All response outputs are stable.
  - Both req*_ready=0.
  - last_grant and op_count are unchanged.
- Supported ctl codes, passed to the alu unchanged: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 EQL, 12 NOR.
  - Any other code: no alu result is used; rsp_out=0, rsp_zero=0, rsp_overflow=0, rsp_err=1.
  - The op is still counted and rotates priority.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1. No requester waits more than one issue.
- Requester obligation: operands and ctl stay stable while valid && !ready. The arbiter does not latch them early.
- Reset mid-operation: a held response is discarded, priority returns to requester 0, and no ready is asserted in the reset cycle.
- op_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- After reset, req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_out=12, rsp_zero=0, rsp_overflow=0, rsp_err=0, op_count=1.
- Both valid every cycle with rsp_ready=1:
  - req0 AND 0x0F0F0F0F & 0xF0F0F0F0; req1 OR 0x00027024 | 0x22DA3709.
  - Required: rsp_id sequence 0,1,0,1; outs 0x00000000 (rsp_zero=1) and 0x22DA772D.
- req1 SUB 3-3 issued, rsp_ready=0 for 3 cycles while req0 is valid:
  - rsp_id=1, rsp_zero=1 held for 3 cycles; req0_ready=0.
  - When rsp_ready rises, req0 is issued that same cycle.
- req0 ADD 0x7FFFFFFF+1 -> rsp_out=0x80000000, rsp_overflow=1. Then req0 ctl=4'b0011 -> rsp_err=1, rsp_out=0.
- Assert reset while rsp_valid=1 and both requesters valid:
  - Next cycle rsp_valid=0, op_count=0.
  - First grant after release goes to requester 0.
- CNT_W=4, 16 back-to-back ops -> op_count wraps to 0, with no lost or duplicated responses (count the rsp_valid & rsp_ready handshakes = 16).
